// File: rtl/thor2023_tlb_pkg.sv
// Shared TLB definitions: command/state encodings and entry field positions,
// used by the maintenance sequencer and the lookup stage.
package thor2023_tlb_pkg;

  localparam int TLB_ENTRIES = 1024;
  localparam int TLB_WIDTH   = 128;
  localparam int TLB_ASID_W  = 12;

  localparam int V_BIT    = TLB_WIDTH - 1;
  localparam int ASID_MSB = TLB_WIDTH - 2;
  localparam int ASID_LSB = TLB_WIDTH - 1 - TLB_ASID_W;

  typedef enum logic [1:0] {
    CMD_WRITE    = 2'd0,
    CMD_READ     = 2'd1,
    CMD_INVALL   = 2'd2,
    CMD_INV_ASID = 2'd3
  } tlb_cmd_t;

  typedef logic [2:0] tlb_state_t;

  localparam tlb_state_t ST_CLEAR    = 3'd0;
  localparam tlb_state_t ST_IDLE     = 3'd1;
  localparam tlb_state_t ST_WR       = 3'd2;
  localparam tlb_state_t ST_RD       = 3'd3;
  localparam tlb_state_t ST_RDW      = 3'd4;
  localparam tlb_state_t ST_SCAN_RD  = 3'd5;
  localparam tlb_state_t ST_SCAN_CHK = 3'd6;
  localparam tlb_state_t ST_FIN      = 3'd7;

endpackage

// File: rtl/thor2023_tlb_maint_if.sv
// Command/response channel between the CSR/miss-handler path (master) and the
// TLB maintenance sequencer (slave).
interface thor2023_tlb_maint_if #(
  parameter int LOG_ENTRIES = 10,
  parameter int WIDTH       = 128,
  parameter int ASID_W      = 12
);
  import thor2023_tlb_pkg::*;

  logic                   req_valid;
  logic                   req_ready;
  tlb_cmd_t               req_cmd;
  logic [LOG_ENTRIES-1:0] req_idx;
  logic [ASID_W-1:0]      req_asid;
  logic [WIDTH-1:0]       req_wdata;
  logic                   resp_valid;
  logic [WIDTH-1:0]       resp_data;
  logic                   done;
  logic                   busy;

  modport master (
    output req_valid, req_cmd, req_idx, req_asid, req_wdata,
    input  req_ready, resp_valid, resp_data, done, busy
  );

  modport slave (
    input  req_valid, req_cmd, req_idx, req_asid, req_wdata,
    output req_ready, resp_valid, resp_data, done, busy
  );

endinterface

// File: rtl/thor2023_tlb_maint.sv
// TLB maintenance sequencer: owns RAM port B, clears the TLB after reset and
// serves write/read/invalidate-all/invalidate-by-ASID commands.
module thor2023_tlb_maint
  import thor2023_tlb_pkg::*;
#(
  parameter int  ENTRIES     = TLB_ENTRIES,
  parameter int  WIDTH       = TLB_WIDTH,
  parameter int  ASID_W      = TLB_ASID_W,
  localparam int LOG_ENTRIES = $clog2(ENTRIES)
) (
  input  logic                   clk,
  input  logic                   rst,
  thor2023_tlb_maint_if.slave    req_if,
  output logic                   tlb_enb,
  output logic                   tlb_web,
  output logic [LOG_ENTRIES-1:0] tlb_addrb,
  output logic [WIDTH-1:0]       tlb_dinb,
  input  logic [WIDTH-1:0]       tlb_doutb
);

  localparam int F_V    = WIDTH - 1;
  localparam int F_AMSB = WIDTH - 2;
  localparam int F_ALSB = WIDTH - 1 - ASID_W;
  localparam logic [LOG_ENTRIES-1:0] PTR_LAST = LOG_ENTRIES'(ENTRIES - 1);
  localparam logic [LOG_ENTRIES-1:0] PTR_ONE  = LOG_ENTRIES'(1);

  tlb_state_t             state_q, state_d;
  logic [LOG_ENTRIES-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0]       resp_data_q, resp_data_d;
  tlb_cmd_t               cmd_q;
  logic [LOG_ENTRIES-1:0] idx_q;
  logic [ASID_W-1:0]      asid_q;
  logic [WIDTH-1:0]       wdata_q;

  logic accept_s, ptr_last_s, hit_s, enb_s, web_s;

  // Status outputs are forced to their reset values while rst is held.
  assign req_if.req_ready  = (state_q == ST_IDLE) && !rst;
  assign req_if.done       = (state_q == ST_FIN) && !rst;
  assign req_if.resp_valid = (state_q == ST_FIN) && (cmd_q == CMD_READ) && !rst;
  assign req_if.busy       = (state_q != ST_IDLE) || rst;
  assign req_if.resp_data  = resp_data_q;

  assign accept_s   = req_if.req_valid && req_if.req_ready;
  assign ptr_last_s = (ptr_q == PTR_LAST);
  assign hit_s      = tlb_doutb[F_V] && (tlb_doutb[F_AMSB:F_ALSB] == asid_q);

  // Sequencer next-state, sweep pointer and read-response capture.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    resp_data_d = resp_data_q;
    case (state_q)
      ST_CLEAR: begin
        if (ptr_last_s) begin
          ptr_d   = '0;
          state_d = (cmd_q == CMD_INVALL) ? ST_FIN : ST_IDLE;
        end else begin
          ptr_d   = ptr_q + PTR_ONE;
        end
      end
      ST_IDLE: begin
        if (accept_s) begin
          case (req_if.req_cmd)
            CMD_WRITE:    state_d = ST_WR;
            CMD_READ:     state_d = ST_RD;
            CMD_INVALL: begin
              state_d = ST_CLEAR;
              ptr_d   = '0;
            end
            CMD_INV_ASID: begin
              state_d = ST_SCAN_RD;
              ptr_d   = '0;
            end
            default:      state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR:      state_d = ST_FIN;
      ST_RD:      state_d = ST_RDW;
      ST_RDW: begin
        resp_data_d = tlb_doutb;
        state_d     = ST_FIN;
      end
      ST_SCAN_RD: state_d = ST_SCAN_CHK;
      // Scan cost is fixed per entry; a hit only adds a write in the same cycle.
      ST_SCAN_CHK: begin
        if (ptr_last_s) begin
          state_d = ST_FIN;
        end else begin
          ptr_d   = ptr_q + PTR_ONE;
          state_d = ST_SCAN_RD;
        end
      end
      ST_FIN:     state_d = ST_IDLE;
      default:    state_d = ST_CLEAR;
    endcase
  end

  // RAM port B drive decoded from state, pointer and the held request.
  always_comb begin
    enb_s     = 1'b0;
    web_s     = 1'b0;
    tlb_addrb = ptr_q;
    tlb_dinb  = '0;
    case (state_q)
      ST_CLEAR: begin
        enb_s = 1'b1;
        web_s = 1'b1;
      end
      ST_WR: begin
        enb_s     = 1'b1;
        web_s     = 1'b1;
        tlb_addrb = idx_q;
        tlb_dinb  = wdata_q;
      end
      ST_RD: begin
        enb_s     = 1'b1;
        tlb_addrb = idx_q;
      end
      ST_SCAN_RD: enb_s = 1'b1;
      ST_SCAN_CHK: begin
        if (hit_s) begin
          enb_s         = 1'b1;
          web_s         = 1'b1;
          tlb_dinb      = tlb_doutb;
          tlb_dinb[F_V] = 1'b0;
        end else begin
          enb_s = 1'b0;
        end
      end
      default: enb_s = 1'b0;
    endcase
  end

  assign tlb_enb = enb_s && !rst;
  assign tlb_web = web_s && !rst;

  // Sequencer state, sweep pointer and response data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      ptr_q       <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      resp_data_q <= resp_data_d;
    end
  end

  // Request fields held for the life of the accepted command.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q   <= CMD_WRITE;
      idx_q   <= '0;
      asid_q  <= '0;
      wdata_q <= '0;
    end else if (accept_s) begin
      cmd_q   <= req_if.req_cmd;
      idx_q   <= req_if.req_idx;
      asid_q  <= req_if.req_asid;
      wdata_q <= req_if.req_wdata;
    end
  end

endmodule

// File: tb/tb_thor2023_tlb_maint.sv
// Self-checking bench for thor2023_tlb_maint: RAM model on port B plus an
// entry-level reference TLB image with directed and randomized commands.
module tb_thor2023_tlb_maint;
  import thor2023_tlb_pkg::*;

  localparam int N  = 1024;
  localparam int W  = 128;
  localparam int AW = 12;
  localparam int LN = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  thor2023_tlb_maint_if #(.LOG_ENTRIES(LN), .WIDTH(W), .ASID_W(AW)) bus ();

  logic          enb, web;
  logic [LN-1:0] addrb;
  logic [W-1:0]  dinb, doutb;

  thor2023_tlb_maint #(.ENTRIES(N), .WIDTH(W), .ASID_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_if    (bus),
    .tlb_enb   (enb),
    .tlb_web   (web),
    .tlb_addrb (addrb),
    .tlb_dinb  (dinb),
    .tlb_doutb (doutb)
  );

  logic [W-1:0] ram     [N];
  logic [W-1:0] ref_mem [N];
  bit           preload = 1'b0;

  // Port B RAM: 1-cycle read latency, output unchanged on writes.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < N; i++) ram[i] <= '1;
    end else if (enb) begin
      if (web) ram[addrb] <= dinb;
      else     doutb      <= ram[addrb];
    end
  end

  int cyc = 0, done_cnt = 0, done_cyc = 0, resp_cnt = 0, wr_cnt = 0, busy_low = 0;
  logic [W-1:0] last_resp = '0;

  // Event counters sampled mid-cycle.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      if (bus.done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc + 1;
      end
      if (bus.resp_valid) begin
        resp_cnt  <= resp_cnt + 1;
        last_resp <= bus.resp_data;
      end
      if (enb && web)  wr_cnt   <= wr_cnt + 1;
      if (!bus.busy)   busy_low <= busy_low + 1;
    end
  end

  int n_checks = 0, n_err = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] mk_entry(input bit v, input logic [AW-1:0] a);
    logic [W-1:0] e;
    e = {$urandom(), $urandom(), $urandom(), $urandom()};
    e[W-1] = v;
    e[W-2 -: AW] = a;
    return e;
  endfunction

  // Reference: what each command does to the TLB image, its cost and port-B writes.
  task automatic model(input tlb_cmd_t c, input logic [LN-1:0] i, input logic [AW-1:0] a,
                       input logic [W-1:0] d, output int lat, output int nwr,
                       output logic [W-1:0] rd);
    rd = '0;
    nwr = 0;
    case (c)
      CMD_WRITE:  begin ref_mem[i] = d; lat = 2; nwr = 1; end
      CMD_READ:   begin rd = ref_mem[i]; lat = 3; end
      CMD_INVALL: begin
        for (int k = 0; k < N; k++) ref_mem[k] = '0;
        lat = N + 1;
        nwr = N;
      end
      default: begin
        for (int k = 0; k < N; k++)
          if (ref_mem[k][W-1] && ref_mem[k][W-2 -: AW] == a) begin
            ref_mem[k][W-1] = 1'b0;
            nwr++;
          end
        lat = 2 * N + 1;
      end
    endcase
  endtask

  task automatic cmp_mem(input string tag);
    int bad = 0;
    for (int k = 0; k < N; k++) if (ram[k] !== ref_mem[k]) bad++;
    chk(tag, bad, 0);
  endtask

  // Issue one command; when wait_done is set, follow it to completion and check it.
  task automatic run(input tlb_cmd_t c, input logic [LN-1:0] i, input logic [AW-1:0] a,
                     input logic [W-1:0] d, input bit wait_done,
                     output int acc, output int prev_done);
    int lat, nwr, n, d0, r0, w0, b0, b1;
    logic [W-1:0] rd;
    model(c, i, a, d, lat, nwr, rd);
    bus.req_valid = 1'b1;
    bus.req_cmd   = c;
    bus.req_idx   = i;
    bus.req_asid  = a;
    bus.req_wdata = d;
    n = 0;
    while (!bus.req_ready && n < 5000) begin step(); n++; end
    chk("accepted", bus.req_ready, 1'b1);
    acc = cyc; prev_done = done_cyc;
    d0 = done_cnt; r0 = resp_cnt; w0 = wr_cnt; b0 = busy_low;
    step();
    bus.req_valid = 1'b0;
    if (wait_done) begin
      n = 0;
      while (done_cnt == d0 && n < lat + 20) begin step(); n++; end
      b1 = busy_low;
      chk("done_latency", done_cyc - acc, lat);
      chk("busy_gap", b1 - b0, 0);
      step(); step();
      chk("done_pulses", done_cnt - d0, 1);
      chk("resp_pulses", resp_cnt - r0, (c == CMD_READ) ? 1 : 0);
      chk("portb_writes", wr_cnt - w0, nwr);
      if (c == CMD_READ) chk("resp_data", last_resp, rd);
    end
  endtask

  // Pulse rst for one cycle and measure the clear sweep that follows.
  task automatic do_reset();
    int n, d0;
    d0 = done_cnt;
    rst = 1'b1;
    step();
    preload = 1'b0;
    chk("rst_ready", bus.req_ready, 1'b0);
    chk("rst_busy", bus.busy, 1'b1);
    chk("rst_enb", enb, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_resp_valid", bus.resp_valid, 1'b0);
    chk("rst_resp_data", bus.resp_data, '0);
    rst = 1'b0;
    #1;
    n = 0;
    while (!bus.req_ready && n < 2000) begin n++; step(); end
    chk("clear_cycles", n, N);
    chk("clear_no_done", done_cnt - d0, 0);
    for (int k = 0; k < N; k++) ref_mem[k] = '0;
    cmp_mem("clear_contents");
  endtask

  initial begin
    int acc, pd, acc2, pd2, r;
    logic [LN-1:0] written[$];
    logic [LN-1:0] ix;
    tlb_cmd_t c;
    bus.req_valid = 1'b0;
    bus.req_cmd   = CMD_WRITE;
    bus.req_idx   = '0;
    bus.req_asid  = '0;
    bus.req_wdata = '0;

    preload = 1'b1;
    do_reset();

    run(CMD_WRITE, 10'h2A5, 12'h000, 128'h8123_4567_89AB_CDEF_0123_4567_89AB_CDEF, 1'b1, acc, pd);
    run(CMD_READ,  10'h2A5, 12'h000, 128'h0, 1'b1, acc, pd);

    run(CMD_WRITE, 10'd3,    12'h0, mk_entry(1'b1, 12'd5), 1'b1, acc, pd);
    run(CMD_WRITE, 10'd7,    12'h0, mk_entry(1'b1, 12'd6), 1'b1, acc, pd);
    run(CMD_WRITE, 10'd1023, 12'h0, mk_entry(1'b1, 12'd5), 1'b1, acc, pd);
    run(CMD_WRITE, 10'd9,    12'h0, mk_entry(1'b0, 12'd5), 1'b1, acc, pd);
    run(CMD_INV_ASID, 10'd0, 12'd5, 128'h0, 1'b1, acc, pd);
    cmp_mem("inv_asid_contents");

    preload = 1'b1;
    step();
    preload = 1'b0;
    for (int k = 0; k < N; k++) ref_mem[k] = '1;
    run(CMD_INVALL, 10'd0, 12'h0, 128'h0, 1'b1, acc, pd);
    cmp_mem("invall_contents");

    // Reset in the middle of an ASID sweep.
    run(CMD_WRITE, 10'd600, 12'h0, mk_entry(1'b1, 12'd2), 1'b1, acc, pd);
    run(CMD_READ,  10'd600, 12'h0, 128'h0, 1'b1, acc, pd);
    run(CMD_INV_ASID, 10'd0, 12'd2, 128'h0, 1'b0, acc, pd);
    r = 0;
    while (!(enb && addrb == 10'd500) && r < 3000) begin step(); r++; end
    chk("reached_ptr500", addrb, 10'd500);
    do_reset();

    // READ held while an ASID sweep runs.
    run(CMD_WRITE, 10'd44, 12'h0, mk_entry(1'b1, 12'd3), 1'b1, acc, pd);
    run(CMD_WRITE, 10'd45, 12'h0, mk_entry(1'b1, 12'd4), 1'b1, acc, pd);
    run(CMD_INV_ASID, 10'd0, 12'd3, 128'h0, 1'b0, acc, pd);
    run(CMD_READ, 10'd44, 12'h0, 128'h0, 1'b1, acc2, pd2);
    chk("scan_done_latency", pd2 - acc, 2 * N + 1);
    chk("held_read_accept", acc2 - pd2, 1);
    cmp_mem("held_read_contents");

    for (int t = 0; t < 24; t++) begin
      r = $urandom_range(0, 19);
      c = (r < 9) ? CMD_WRITE : (r < 17) ? CMD_READ : (r < 19) ? CMD_INV_ASID : CMD_INVALL;
      ix = LN'($urandom_range(0, N - 1));
      if (c == CMD_READ && written.size() > 0 && $urandom_range(0, 3) != 0)
        ix = written[$urandom_range(0, written.size() - 1)];
      if (c == CMD_WRITE) written.push_back(ix);
      run(c, ix, AW'($urandom_range(1, 3)),
          mk_entry(1'($urandom_range(0, 1)), AW'($urandom_range(1, 3))), 1'b1, acc, pd);
    end
    cmp_mem("random_contents");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
